// File: rtl/gpu_bus_master_if.sv
// GPU register-port bundle between the bus master and the GPU register file.
// master drives strobes and write data; slave returns read data and flow status.
interface gpu_bus_master_if;
  logic        gpu_en;
  logic        to_gp0;
  logic        to_gp1;
  logic        main_bus_re;
  logic [31:0] main_bus;
  logic        main_bus_rdy;
  logic        fifo_full;
  logic [31:0] gpu_read;
  logic [31:0] gpu_stat;

  modport master (
    output gpu_en, to_gp0, to_gp1, main_bus_re, main_bus,
    input  main_bus_rdy, fifo_full, gpu_read, gpu_stat
  );

  modport slave (
    input  gpu_en, to_gp0, to_gp1, main_bus_re, main_bus,
    output main_bus_rdy, fifo_full, gpu_read, gpu_stat
  );
endinterface

// File: rtl/gpu_bus_master.sv
// Initiator for the GP0/GP1/GPUREAD/GPUSTAT register port: one command at a time,
// FIFO back-pressure, slow reads and stall timeout. Option: GPU_BUS_STAT_POLL_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_WRITE | issuing a GP0/GP1 write, GP0 may stall on fifo_full
// S_READ  | holding GPUREAD/GPUSTAT read strobes until main_bus_rdy
// S_POLL  | (GPU_BUS_STAT_POLL_EN) GPUSTAT polling until bit 26 is set
module gpu_bus_master #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_gp1,
  input  logic             cmd_read,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  gpu_bus_master_if.master bus
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

`ifdef GPU_BUS_STAT_POLL_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_POLL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
`endif

  state_t          state, state_n;
  logic            gp1_q;
  logic [31:0]     main_bus_q;
  logic [TO_W-1:0] to_cnt;

  logic gpu_en_c, to_gp0_c, to_gp1_c, re_c;
  logic stall, abort, wr_done, rd_done;

  always_comb begin
    state_n  = state;
    gpu_en_c = 1'b0;
    to_gp0_c = 1'b0;
    to_gp1_c = 1'b0;
    re_c     = 1'b0;
    stall    = 1'b0;
    wr_done  = 1'b0;
    rd_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_read) state_n = S_READ;
`ifdef GPU_BUS_STAT_POLL_EN
          else if (!cmd_gp1) state_n = S_POLL;
`endif
          else state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (gp1_q) begin
          gpu_en_c = 1'b1;
          to_gp1_c = 1'b1;
          state_n  = S_IDLE;
        end else if (!bus.fifo_full) begin
          gpu_en_c = 1'b1;
          to_gp0_c = 1'b1;
          wr_done  = 1'b1;
          state_n  = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_READ: begin
        gpu_en_c = 1'b1;
        re_c     = 1'b1;
        to_gp0_c = !gp1_q;
        to_gp1_c = gp1_q;
        if (bus.main_bus_rdy) begin
          rd_done = 1'b1;
          state_n = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
`ifdef GPU_BUS_STAT_POLL_EN
      S_POLL: begin
        gpu_en_c = 1'b1;
        re_c     = 1'b1;
        to_gp1_c = 1'b1;
        // a ready GPUSTAT without bit 26 is still a stall for timeout purposes
        if (bus.main_bus_rdy && bus.gpu_stat[26]) state_n = S_WRITE;
        else stall = 1'b1;
      end
`endif
      default: state_n = S_IDLE;
    endcase
    abort = stall && (to_cnt == TO_LAST);
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      gp1_q      <= 1'b0;
      main_bus_q <= '0;
      to_cnt     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      wr_count   <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (state == S_IDLE && cmd_valid) begin
        main_bus_q <= cmd_data;
        gp1_q      <= cmd_gp1;
        to_cnt     <= '0;
      end else if (abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_data  <= 32'hFFFF_FFFF;
        to_cnt    <= '0;
      end else if (stall) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (rd_done) begin
        rsp_valid <= 1'b1;
        rsp_data  <= gp1_q ? bus.gpu_stat : bus.gpu_read;
      end
      if (wr_done) wr_count <= wr_count + CNT_W'(1);
    end
  end

  assign cmd_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign bus.gpu_en      = gpu_en_c;
  assign bus.to_gp0      = to_gp0_c;
  assign bus.to_gp1      = to_gp1_c;
  assign bus.main_bus_re = re_c;
  assign bus.main_bus    = main_bus_q;

endmodule

// File: tb/tb_gpu_bus_master.sv
// Bench for gpu_bus_master: directed steps plus random commands against a cycle-count model.
module tb_gpu_bus_master;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_gp1, cmd_read;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [15:0] wr_count;

  int          total = 0;
  int          bad = 0;
  int          exp_wr = 0;
  logic [31:0] exp_rsp = '0;

  gpu_bus_master_if bus ();

  gpu_bus_master #(.TIMEOUT_CYC(T), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_gp1   (cmd_gp1),
    .cmd_read  (cmd_read),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wr_count  (wr_count),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.gpu_en, bus.to_gp0, bus.to_gp1, bus.main_bus_re};
  endfunction

  // Expected {gpu_en,to_gp0,to_gp1,main_bus_re} in cycle i after acceptance, d stall cycles.
  function automatic logic [31:0] exp_strobe(input bit gp1, input bit rd, input int d, input int i);
    int held;
    if (rd) begin
      held = (d < T) ? d + 1 : T;
      return (i < held) ? {28'd0, 1'b1, !gp1, gp1, 1'b1} : 32'd0;
    end
    if (gp1) return (i == 0) ? 32'b1010 : 32'd0;
    return (i == d && d < T) ? 32'b1100 : 32'd0;
  endfunction

  task automatic run_cmd(input bit gp1, input bit rd, input logic [31:0] data,
                         input int d, input logic [31:0] rval);
    bit abort, resp;
    int end_i;
    abort = (d >= T) && !(gp1 && !rd);
    end_i = (!rd && gp1) ? 1 : (abort ? T : d + 1);
    resp  = rd || abort;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_gp1 = gp1; cmd_read = rd; cmd_data = data;
    #1;
    check("idle_busy_ready", {30'd0, busy, cmd_ready}, 32'b01);
    for (int i = 0; i <= end_i; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      if (rd) begin
        bus.fifo_full    = 1'($urandom);
        bus.main_bus_rdy = (i >= d);
        if (i == d) begin
          bus.gpu_read = gp1 ? ~rval : rval;
          bus.gpu_stat = gp1 ? rval : ~rval;
        end else begin
          bus.gpu_read = $urandom;
          bus.gpu_stat = $urandom;
        end
      end else begin
        bus.fifo_full    = (i < d);
        bus.main_bus_rdy = 1'($urandom);
      end
      #1;
      check("strobes", strobes(), exp_strobe(gp1, rd, d, i));
      check("busy_rspvalid", {30'd0, busy, rsp_valid}, {30'd0, i < end_i, (i == end_i) && resp});
      if (i == 0 && !rd) check("main_bus", bus.main_bus, data);
    end
    if (!rd && !gp1 && !abort) exp_wr++;
    if (abort) exp_rsp = 32'hFFFF_FFFF;
    else if (rd) exp_rsp = rval;
    check("rsp_data", rsp_data, exp_rsp);
    check("wr_count", {16'd0, wr_count}, 32'(exp_wr % 65536));
    check("ready_after", {31'd0, cmd_ready}, 32'd1);
    if (resp) check("rsp_err", {31'd0, rsp_err}, {31'd0, abort});
    bus.fifo_full    = 1'b0;
    bus.main_bus_rdy = 1'b0;
  endtask

  initial begin
    bit rgp1, rrd;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_gp1 = 1'b0; cmd_read = 1'b0; cmd_data = '0;
    bus.fifo_full = 1'b0; bus.main_bus_rdy = 1'b0; bus.gpu_read = '0; bus.gpu_stat = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_strobes", strobes(), 32'd0);
    check("rst_flags", {28'd0, busy, cmd_ready, rsp_valid, rsp_err}, 32'b0100);
    check("rst_data", rsp_data | bus.main_bus | {16'd0, wr_count}, 32'd0);
    rst = 1'b1;

`ifndef GPU_BUS_STAT_POLL_EN
    run_cmd(1'b0, 1'b0, 32'hE100_0000, 0, 32'd0);
    run_cmd(1'b0, 1'b0, 32'hE200_1234, 5, 32'd0);
    run_cmd(1'b0, 1'b0, 32'hE300_0001, T - 1, 32'd0);
    run_cmd(1'b0, 1'b0, 32'hE400_0002, T, 32'd0);
`endif
    run_cmd(1'b1, 1'b1, 32'd0, 3, 32'h1480_2000);
    run_cmd(1'b0, 1'b1, 32'd0, 100, 32'd0);
    run_cmd(1'b0, 1'b1, 32'd0, T - 1, 32'hCAFE_0007);
    run_cmd(1'b1, 1'b1, 32'd0, 0, 32'h1C00_0000);
    run_cmd(1'b1, 1'b0, 32'h0800_0001, 4, 32'd0);

`ifdef GPU_BUS_STAT_POLL_EN
    @(negedge clk);
    cmd_valid = 1'b1; cmd_gp1 = 1'b0; cmd_read = 1'b0; cmd_data = 32'hA000_0000;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      bus.main_bus_rdy = 1'b1;
      bus.fifo_full    = 1'b0;
      bus.gpu_stat     = (i >= 2) ? 32'h0400_0000 : 32'hFBFF_FFFF;
      #1;
      check("poll_strobes", strobes(), (i < 3) ? 32'b1011 : ((i == 3) ? 32'b1100 : 32'd0));
      check("poll_busy_rsp", {30'd0, busy, rsp_valid}, {30'd0, i < 4, 1'b0});
    end
    exp_wr++;
    check("poll_wr_count", {16'd0, wr_count}, 32'(exp_wr));
    check("poll_rsp_data", rsp_data, exp_rsp);
    bus.main_bus_rdy = 1'b0;
`endif

    for (int n = 0; n < 40; n++) begin
      rgp1 = 1'($urandom);
      rrd  = 1'($urandom);
`ifdef GPU_BUS_STAT_POLL_EN
      if (!rgp1) rrd = 1'b1;
`endif
      run_cmd(rgp1, rrd, $urandom, int'($urandom_range(0, T + 2)), $urandom);
    end

    // synchronous reset in the middle of a stalled read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_gp1 = 1'b0; cmd_read = 1'b1; cmd_data = 32'h5555_AAAA;
    @(negedge clk);
    cmd_valid = 1'b0; bus.main_bus_rdy = 1'b0;
    #1;
    check("pre_rst_strobes", strobes(), 32'b1101);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", strobes(), 32'd0);
    check("mid_rst_flags", {29'd0, busy, cmd_ready, rsp_valid}, 32'b010);
    check("mid_rst_data", rsp_data | bus.main_bus | {16'd0, wr_count}, 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_rsp", {30'd0, busy, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
